seq_alu_w: RTL
==============

# seq_alu_w

Parametrised, fully synchronous sequential ALU for signed add, compare, multiply and divide on WIDTH-bit operands with a start/done handshake. Every register runs on one clock with one synchronous reset. Multiply and divide iterate one bit per cycle over a shared magnitude datapath, and results are widened to 2·WIDTH bits. It sits behind the operand/opcode front end and presents a registered result to the display/readout logic.

## Interface
- WIDTH, 16, operand width in bits; legal range is 4 to 32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- opcode  in  2  00 add, 01 mul, 10 div, 11 compare.
- opA  in  WIDTH  signed operand A (dividend for div).
- opB  in  WIDTH  signed operand B (divisor for div).
- res  out  2·WIDTH  signed result; holds until the next accepted start.
- rem  out  WIDTH  signed remainder (present only with SEQ_ALU_REM_EN).
- busy  out  1  high from the accepting edge until the edge that raises done.
- done  out  1  one-cycle pulse; res (and rem) are valid from that cycle onward.
- dz  out  1  divide-by-zero flag; updated with done; cleared when the next op is accepted.

## Operation
- States are IDLE, ITER, FIN.
- IDLE with start=1:
  - latch opcode, opA and opB; clear dz; set busy.
  - add, compare, or div with opB=0: go to FIN.
  - mul, or div with nonzero opB: go to ITER with cnt=0.
- Operands, opcode and start changes while busy are ignored.
- ITER: one shift-add (mul) or non-restoring shift-subtract (div) step per cycle on |opA| and |opB|, using a 2·WIDTH+1 accumulator. After cnt reaches WIDTH−1, go to FIN.
- FIN: write res (and rem), pulse done, drop busy, go to IDLE.
- add: res = sign-extended opA + sign-extended opB; there is no overflow at 2·WIDTH bits.
- compare: res = 0 if opA==opB, 1 if opA>opB, all-ones if opA<opB (signed).
- mul: res = signed product at full 2·WIDTH bits, including MIN·MIN = +2^(2·WIDTH−2).
- div:
  - quotient truncates toward zero and is sign-extended into res.
  - remainder takes the sign of opA.
  - MIN/−1 gives res = +2^(WIDTH−1) with no overflow.
- Sign fix-up: sign of result = opA[MSB] XOR opB[MSB]; negation happens in FIN (two's complement).
- Divide by zero: res = all-ones, rem = opA, dz = 1; no iteration is performed.
- rst=1 at any edge forces IDLE. res, rem, cnt and the accumulator go to 0; busy, done and dz go to 0. An in-flight op is abandoned with no done.

## Timing
- Edge 0 is the edge that samples start=1 in IDLE.
- add, compare and div-by-zero: res and done are updated at edge 1. Latency is 1 cycle.
- mul and div: iterations run at edges 1..WIDTH, FIN at edge WIDTH+1. Latency is WIDTH+1 cycles (17 at default).
- done is high for exactly one cycle.
- start may be asserted in the cycle done is high; it is sampled at the next edge in IDLE. Back-to-back throughput is latency+1.
- start held high continuously re-triggers on every IDLE visit.

## Configuration
- SEQ_ALU_REM_EN defined: the rem port exists and carries the signed remainder on div. rem = 0 for add, mul and compare.
- Not defined: rem port and remainder fix-up logic are removed; res behaviour is unchanged.

## Structure
- Package seq_alu_pkg holds:
  - opcode localparams OP_ADD, OP_MUL, OP_DIV, OP_CMP;
  - the state enum;
  - a function for the CNT_W bit count.
- Sub-module md_step (combinational, parametrised by WIDTH) computes one mul or div iteration from accumulator, |B| and mode. The top keeps the FSM, counter, latches and sign fix-up.

## Test plan
- WIDTH=16, add 0x7FFF+0x0001 -> res 0x00008000, done at edge 1, busy high for 1 cycle.
- mul 0xFFFD·0x0007 (−3·7) -> res 0xFFFFFFEB, done exactly 17 cycles after edge 0. Also 0x8000·0x8000 -> 0x40000000.
- div 0xFFF9/0x0002 (−7/2) -> res 0xFFFFFFFD, rem 0xFFFF, dz=0. Also 0x8000/0xFFFF -> res 0x00008000, rem 0.
- div 0x0005/0x0000 -> res 0xFFFFFFFF, rem 0x0005, dz=1, done at edge 1. The next accepted add clears dz.
- compare (0xFFFF,0x0001) -> 0xFFFFFFFF; (0x0001,0xFFFF) -> 0x00000001; equal -> 0. Toggling opcode/opA mid-mul does not alter the result.
- rst pulsed at cycle 8 of a mul -> all outputs 0, no done. A new start after reset completes normally.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and counter sizing for seq_alu_w.
// Build option SEQ_ALU_REM_EN (used by seq_alu_w) enables the remainder output.
package seq_alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_CMP = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   // Bits needed to count iterations 0 .. width-1.
   function automatic int cnt_w(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/seq_alu_w_md_step.sv
// One iteration of the shared magnitude datapath: shift-add multiply or
// non-restoring shift-subtract divide on a 2*WIDTH+1 bit accumulator.
module md_step #(
   parameter int WIDTH = 16
) (
   input  logic [2*WIDTH:0]   acc,
   input  logic [WIDTH-1:0]   b,
   input  logic               mode_div,
   output logic [2*WIDTH:0]   acc_next
);

   logic [WIDTH:0] hi_sum;
   logic [WIDTH:0] r_sh;
   logic [WIDTH:0] r_new;

   always_comb begin
      // Multiply: upper W+1 bits accumulate |B|, lower W bits hold the
      // remaining multiplier bits; everything shifts right each step.
      hi_sum = acc[2*WIDTH:WIDTH] + {1'b0, b};
      // Divide: upper W+1 bits are the signed partial remainder, lower W bits
      // shift dividend bits out and quotient bits in.
      r_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      r_new  = acc[2*WIDTH] ? (r_sh + {1'b0, b}) : (r_sh - {1'b0, b});
      if (mode_div) begin
         acc_next = {r_new, acc[WIDTH-2:0], ~r_new[WIDTH]};
      end else begin
         acc_next = {1'b0, (acc[0] ? hi_sum : acc[2*WIDTH:WIDTH]), acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/seq_alu_w.sv
// Sequential signed ALU (add, compare, iterative mul/div) with start/done handshake.
// Define SEQ_ALU_REM_EN to add the signed remainder output rem.
module seq_alu_w
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           opcode,
   input  logic [WIDTH-1:0]     opA,
   input  logic [WIDTH-1:0]     opB,
   output logic [2*WIDTH-1:0]   res,
`ifdef SEQ_ALU_REM_EN
   output logic [WIDTH-1:0]     rem,
`endif
   output logic                 busy,
   output logic                 done,
   output logic                 dz,
   output logic [1:0]           fsm_state
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam int AW    = 2*WIDTH + 1;

   // Handshake: start is honoured only in IDLE; busy covers the accepting
   // edge up to the edge that raises done; done is a one-cycle pulse and res
   // (and rem) hold from that cycle until the next accepted start.

   state_t             state;
   state_t             next_state;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   a_in_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [CNT_W-1:0]   cnt;
   logic [AW-1:0]      acc;
   logic [AW-1:0]      acc_next;
   logic [2*WIDTH-1:0] fin_res;
   logic [2*WIDTH-1:0] mag2;
   logic               neg;
   logic               b_zero;
   logic               iter_last;
   logic               mode_div;

   assign a_in_mag  = opA[WIDTH-1] ? -opA : opA;
   assign b_mag     = b_q[WIDTH-1] ? -b_q : b_q;
   assign b_zero    = (b_q == '0);
   assign neg       = a_q[WIDTH-1] ^ b_q[WIDTH-1];
   assign iter_last = (cnt == CNT_W'(WIDTH-1));
   assign mode_div  = (op_q == OP_DIV);
   assign fsm_state = state;

   md_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc),
      .b        (b_mag),
      .mode_div (mode_div),
      .acc_next (acc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (opcode == OP_MUL || (opcode == OP_DIV && opB != '0))
                  next_state = S_ITER;
               else
                  next_state = S_FIN;
            end
         end
         S_ITER:  if (iter_last) next_state = S_FIN;
         S_FIN:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Result formation; magnitudes from the datapath get their sign here.
   always_comb begin
      fin_res = '0;
      mag2    = '0;
      case (op_q)
         OP_ADD: fin_res = {{WIDTH{a_q[WIDTH-1]}}, a_q} + {{WIDTH{b_q[WIDTH-1]}}, b_q};
         OP_CMP: begin
            if ($signed(a_q) > $signed(b_q)) fin_res = {{(2*WIDTH-1){1'b0}}, 1'b1};
            else if (a_q != b_q)             fin_res = '1;
         end
         OP_MUL: begin
            mag2    = acc[2*WIDTH-1:0];
            fin_res = neg ? -mag2 : mag2;
         end
         OP_DIV: begin
            if (b_zero) begin
               fin_res = '1;
            end else begin
               mag2    = {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
               fin_res = neg ? -mag2 : mag2;
            end
         end
         default: fin_res = '0;
      endcase
   end

`ifdef SEQ_ALU_REM_EN
   logic [WIDTH-1:0] r_fix;
   logic [WIDTH-1:0] fin_rem;

   // A negative final partial remainder lies in [-|B|, 0); adding |B| back
   // lands in [0, |B|), so the low WIDTH bits are exact.
   always_comb begin
      r_fix   = acc[AW-1] ? (acc[AW-2:WIDTH] + b_mag) : acc[AW-2:WIDTH];
      fin_rem = '0;
      if (op_q == OP_DIV) begin
         if (b_zero) fin_rem = a_q;
         else        fin_rem = a_q[WIDTH-1] ? -r_fix : r_fix;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= OP_ADD;
         a_q  <= '0;
         b_q  <= '0;
         cnt  <= '0;
         acc  <= '0;
         res  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         dz   <= 1'b0;
`ifdef SEQ_ALU_REM_EN
         rem  <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q <= opcode;
                  a_q  <= opA;
                  b_q  <= opB;
                  dz   <= 1'b0;
                  busy <= 1'b1;
                  cnt  <= '0;
                  acc  <= {{(WIDTH+1){1'b0}}, a_in_mag};
               end
            end
            S_ITER: begin
               acc <= acc_next;
               cnt <= cnt + CNT_W'(1);
            end
            S_FIN: begin
               res  <= fin_res;
               dz   <= mode_div && b_zero;
               done <= 1'b1;
               busy <= 1'b0;
`ifdef SEQ_ALU_REM_EN
               rem  <= fin_rem;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
